// File: rtl/sram_like_responder.sv
`default_nettype none
// ============================================================================
//  Module   : sram_like_responder
//  Purpose  : Responder end of the SRAM-like request/response bus. It accepts
//             address-phase requests into an internal word-addressed memory.
//             Responses are returned in order on data_ok after at least LAT
//             cycles. Up to DEPTH requests may be outstanding at once.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W  word-index width; memory holds 2**ADDR_W 32-bit words
//    DEPTH   maximum outstanding requests (power of two, 2..16)
//    LAT     minimum cycles from acceptance to data_ok (1..8)
//  Ports
//    clk       in   1   clock
//    reset     in   1   synchronous active-high reset
//    req       in   1   request valid
//    wr        in   1   1 = write, 0 = read
//    size      in   2   transfer size (accepted, not used)
//    wstrb     in   4   byte write enables for writes
//    addr      in   32  byte address; word index is addr[ADDR_W+1:2]
//    wdata     in   32  write data
//    throttle  in   1   forces addr_ok low
//    addr_ok   out  1   request accepted when req & addr_ok
//    data_ok   out  1   one in-order response this cycle
//    rdata     out  32  read word (zero for write responses)
// ============================================================================
module sram_like_responder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4,
    parameter int LAT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        throttle,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AGE_W = $clog2(LAT + 1);

    localparam logic [PTR_W:0]   c_full      = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   c_cnt_one   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] c_ptr_one   = PTR_W'(1);
    localparam logic [AGE_W-1:0] c_age_max   = AGE_W'(LAT);
    localparam logic [AGE_W-1:0] c_age_one   = AGE_W'(1);
    localparam logic [AGE_W:0]   c_lat_wide  = (AGE_W + 1)'(LAT);
    localparam logic [AGE_W:0]   c_one_wide  = (AGE_W + 1)'(1);

    // Backing memory, never reset so contents survive a mid-run reset
    logic [31:0]       r_mem [2**ADDR_W];

    // Response FIFO state
    logic [31:0]       r_data [DEPTH];
    logic [AGE_W-1:0]  r_age  [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [PTR_W:0]    r_count;
    logic              r_data_ok;
    logic [31:0]       r_rdata;

    logic [ADDR_W-1:0] w_index;
    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_rd_word;
    logic [PTR_W-1:0]  w_head_n;
    logic [PTR_W:0]    w_count_n;
    logic [AGE_W-1:0]  w_age_n [DEPTH];
    logic [31:0]       w_head_data_n;
    logic              w_data_ok_n;
    logic              w_unused_bits;

    assign w_unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

    assign w_index = addr[ADDR_W+1:2];
    assign addr_ok = ~reset & ~throttle & (r_count != c_full);
    assign w_push  = req & addr_ok;
    // The presented head is always consumed: the bus has no back-pressure
    assign w_pop   = r_data_ok;

    // Reads capture the word at acceptance; write responses carry zero data
    assign w_rd_word = wr ? 32'h0 : r_mem[w_index];

    assign w_head_n = w_pop ? (r_head + c_ptr_one) : r_head;

    always_comb begin
        w_count_n = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_n = r_count + c_cnt_one;
            2'b01:   w_count_n = r_count - c_cnt_one;
            default: w_count_n = r_count;
        endcase
    end

    // Ages saturate at LAT; stale slots age harmlessly and are zeroed on push
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_age_n[i] = (r_age[i] == c_age_max) ? c_age_max : (r_age[i] + c_age_one);
        end
        if (w_push) begin
            w_age_n[r_tail] = '0;
        end
    end

    // Next head may be the entry being pushed right now (empty or draining FIFO)
    assign w_head_data_n = (w_push && (r_tail == w_head_n)) ? w_rd_word : r_data[w_head_n];

    // Presented in the cycle where age reaches LAT-1, i.e. LAT cycles after
    // acceptance; compared as age+1 >= LAT to stay well-formed for LAT=1
    assign w_data_ok_n = (w_count_n != '0) &&
                         (({1'b0, w_age_n[w_head_n]} + c_one_wide) >= c_lat_wide);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_data_ok <= 1'b0;
            r_rdata   <= 32'h0;
            for (int i = 0; i < DEPTH; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            r_head    <= w_head_n;
            r_tail    <= w_push ? (r_tail + c_ptr_one) : r_tail;
            r_count   <= w_count_n;
            r_data_ok <= w_data_ok_n;
            for (int i = 0; i < DEPTH; i++) begin
                r_age[i] <= w_age_n[i];
            end
            // rdata holds its last value while nothing is presented
            if (w_data_ok_n) begin
                r_rdata <= w_head_data_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_tail] <= w_rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    r_mem[w_index][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign data_ok = r_data_ok;
    assign rdata   = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_like_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_like_responder
//  Purpose  : Directed self-checking bench. Four responders (LAT 1/2/4/8,
//             DEPTH 4) share one stimulus; each scenario checks one of them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_like_responder;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        req      = 1'b0;
    logic        wr       = 1'b0;
    logic [1:0]  size     = 2'd2;
    logic [3:0]  wstrb    = 4'h0;
    logic [31:0] addr     = 32'h0;
    logic [31:0] wdata    = 32'h0;
    logic        throttle = 1'b0;

    logic        addr_ok_l1, data_ok_l1;
    logic        addr_ok_l2, data_ok_l2;
    logic        addr_ok_l4, data_ok_l4;
    logic        addr_ok_l8, data_ok_l8;
    logic [31:0] rdata_l1, rdata_l2, rdata_l4, rdata_l8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_like_responder #(.ADDR_W(10), .DEPTH(4), .LAT(1)) u_l1 (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .throttle(throttle),
        .addr_ok(addr_ok_l1), .data_ok(data_ok_l1), .rdata(rdata_l1));

    sram_like_responder #(.ADDR_W(10), .DEPTH(4), .LAT(2)) u_l2 (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .throttle(throttle),
        .addr_ok(addr_ok_l2), .data_ok(data_ok_l2), .rdata(rdata_l2));

    sram_like_responder #(.ADDR_W(10), .DEPTH(4), .LAT(4)) u_l4 (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .throttle(throttle),
        .addr_ok(addr_ok_l4), .data_ok(data_ok_l4), .rdata(rdata_l4));

    sram_like_responder #(.ADDR_W(10), .DEPTH(4), .LAT(8)) u_l8 (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .throttle(throttle),
        .addr_ok(addr_ok_l8), .data_ok(data_ok_l8), .rdata(rdata_l8));

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        req   = 1'b0;
        wr    = 1'b0;
        wstrb = 4'h0;
        addr  = 32'h0;
        wdata = 32'h0;
    endtask

    task automatic set_req(input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        req   = 1'b1;
        wr    = w;
        addr  = a;
        wdata = d;
        wstrb = s;
    endtask

    // Leaves the bench in cycle 0 right after a reset edge
    task automatic pulse_reset();
        set_idle();
        throttle = 1'b0;
        reset    = 1'b1;
        next_cycle();
        reset    = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        next_cycle();
        next_cycle();
        #1;
        checks++;
        if (addr_ok_l2 !== 1'b0) begin errors++; $display("FAIL reset_addr_ok got=%b exp=0", addr_ok_l2); end
        checks++;
        if (data_ok_l2 !== 1'b0) begin errors++; $display("FAIL reset_data_ok got=%b exp=0", data_ok_l2); end
        checks++;
        if (rdata_l2 !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=00000000", rdata_l2); end
        checks++;
        if (addr_ok_l8 !== 1'b0) begin errors++; $display("FAIL reset_addr_ok_l8 got=%b exp=0", addr_ok_l8); end
        reset = 1'b0;
        #1;
        checks++;
        if (addr_ok_l2 !== 1'b1) begin errors++; $display("FAIL post_reset_addr_ok got=%b exp=1", addr_ok_l2); end
    endtask

    task automatic test_write_read();
        logic [4:0] e_dok;
        logic [31:0] e_rd;
        e_dok = 5'b01100;
        pulse_reset();
        for (int c = 0; c < 5; c++) begin
            case (c)
                0:       set_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
                1:       set_req(1'b0, 32'h10, 32'h0, 4'h0);
                default: set_idle();
            endcase
            #1;
            if (c < 2) begin
                checks++;
                if (addr_ok_l2 !== 1'b1) begin errors++; $display("FAIL wr_rd_addr_ok c%0d got=%b exp=1", c, addr_ok_l2); end
            end
            checks++;
            if (data_ok_l2 !== e_dok[c]) begin errors++; $display("FAIL wr_rd_data_ok c%0d got=%b exp=%b", c, data_ok_l2, e_dok[c]); end
            if (c >= 2) begin
                e_rd = (c == 2) ? 32'h0 : 32'hDEADBEEF;
                checks++;
                if (rdata_l2 !== e_rd) begin errors++; $display("FAIL wr_rd_rdata c%0d got=%h exp=%h", c, rdata_l2, e_rd); end
            end
            next_cycle();
        end
    endtask

    task automatic test_byte_strobes();
        logic [7:0]  e_dok;
        logic [31:0] e_rd;
        e_dok = 8'b0111_1100;
        pulse_reset();
        for (int c = 0; c < 8; c++) begin
            case (c)
                0:       set_req(1'b1, 32'h20, 32'h11223344, 4'hF);
                1:       set_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
                2:       set_req(1'b0, 32'h20, 32'h0, 4'h0);
                3:       set_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
                4:       set_req(1'b0, 32'hFFFF0022, 32'h0, 4'h0);  // aliases word 8
                default: set_idle();
            endcase
            #1;
            checks++;
            if (data_ok_l2 !== e_dok[c]) begin errors++; $display("FAIL strobe_data_ok c%0d got=%b exp=%b", c, data_ok_l2, e_dok[c]); end
            if (e_dok[c]) begin
                e_rd = (c == 4 || c == 6) ? 32'h11BB33DD : 32'h0;
                checks++;
                if (rdata_l2 !== e_rd) begin errors++; $display("FAIL strobe_rdata c%0d got=%h exp=%h", c, rdata_l2, e_rd); end
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic        e_dok;
        logic [31:0] e_rd;
        pulse_reset();
        for (int k = 0; k < 8; k++) begin
            set_req(1'b1, 32'(4 * k), 32'h10000000 + 32'(k) * 32'h00110011, 4'hF);
            next_cycle();
        end
        set_idle();
        next_cycle();
        next_cycle();
        for (int k = 0; k < 10; k++) begin
            if (k < 8) set_req(1'b0, 32'(4 * k), 32'h0, 4'h0);
            else       set_idle();
            #1;
            if (k < 8) begin
                checks++;
                if (addr_ok_l1 !== 1'b1) begin errors++; $display("FAIL stream_addr_ok c%0d got=%b exp=1", k, addr_ok_l1); end
            end
            e_dok = (k >= 1 && k <= 8);
            checks++;
            if (data_ok_l1 !== e_dok) begin errors++; $display("FAIL stream_data_ok c%0d got=%b exp=%b", k, data_ok_l1, e_dok); end
            if (e_dok) begin
                e_rd = 32'h10000000 + 32'(k - 1) * 32'h00110011;
                checks++;
                if (rdata_l1 !== e_rd) begin errors++; $display("FAIL stream_rdata c%0d got=%h exp=%h", k, rdata_l1, e_rd); end
            end
            next_cycle();
        end
    endtask

    task automatic test_full();
        logic [9:0] e_aok;
        logic [9:0] e_dok;
        e_aok = 10'b10_0000_1111;
        e_dok = 10'b11_0000_0000;
        pulse_reset();
        for (int c = 0; c < 10; c++) begin
            set_req(1'b0, 32'h0, 32'h0, 4'h0);
            #1;
            checks++;
            if (addr_ok_l8 !== e_aok[c]) begin errors++; $display("FAIL full_addr_ok c%0d got=%b exp=%b", c, addr_ok_l8, e_aok[c]); end
            checks++;
            if (data_ok_l8 !== e_dok[c]) begin errors++; $display("FAIL full_data_ok c%0d got=%b exp=%b", c, data_ok_l8, e_dok[c]); end
            next_cycle();
        end
        set_idle();
    endtask

    task automatic test_throttle();
        logic [5:0]  e_aok;
        logic [8:0]  e_dok;
        logic [31:0] e_rd;
        e_aok = 6'b10_0011;
        e_dok = 9'b0_1000_1100;
        pulse_reset();
        for (int c = 0; c < 9; c++) begin
            throttle = (c >= 2 && c <= 4);
            case (c)
                0:       set_req(1'b1, 32'h40, 32'h5A5A1234, 4'hF);
                1:       set_req(1'b0, 32'h40, 32'h0, 4'h0);
                2, 3, 4: set_req(1'b1, 32'h40, 32'hFFFFFFFF, 4'hF);
                5:       set_req(1'b0, 32'h40, 32'h0, 4'h0);
                default: set_idle();
            endcase
            #1;
            if (c < 6) begin
                checks++;
                if (addr_ok_l2 !== e_aok[c]) begin errors++; $display("FAIL throttle_addr_ok c%0d got=%b exp=%b", c, addr_ok_l2, e_aok[c]); end
            end
            checks++;
            if (data_ok_l2 !== e_dok[c]) begin errors++; $display("FAIL throttle_data_ok c%0d got=%b exp=%b", c, data_ok_l2, e_dok[c]); end
            if (c == 2 || c == 3 || c == 4 || c == 7) begin
                e_rd = (c == 2) ? 32'h0 : 32'h5A5A1234;
                checks++;
                if (rdata_l2 !== e_rd) begin errors++; $display("FAIL throttle_rdata c%0d got=%h exp=%h", c, rdata_l2, e_rd); end
            end
            next_cycle();
        end
        throttle = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic        e_dok;
        logic [31:0] e_rd;
        pulse_reset();
        for (int c = 0; c < 23; c++) begin
            reset = (c == 10);
            case (c)
                0:       set_req(1'b1, 32'h80, 32'h600DF00D, 4'hF);
                1, 7, 9: set_req(1'b0, 32'h80, 32'h0, 4'h0);
                8:       set_req(1'b0, 32'h84, 32'h0, 4'h0);
                17:      set_req(1'b0, 32'h80, 32'h0, 4'h0);
                default: set_idle();
            endcase
            #1;
            e_dok = (c == 4 || c == 5 || c == 21);
            checks++;
            if (data_ok_l4 !== e_dok) begin errors++; $display("FAIL rstmid_data_ok c%0d got=%b exp=%b", c, data_ok_l4, e_dok); end
            if (c == 4 || c == 5 || c == 6 || c == 10 || c == 11 || c == 21) begin
                e_rd = (c == 4 || c == 11) ? 32'h0 : 32'h600DF00D;
                checks++;
                if (rdata_l4 !== e_rd) begin errors++; $display("FAIL rstmid_rdata c%0d got=%h exp=%h", c, rdata_l4, e_rd); end
            end
            if (c >= 7 && c <= 11) begin
                checks++;
                if (addr_ok_l4 !== (c != 10)) begin errors++; $display("FAIL rstmid_addr_ok c%0d got=%b exp=%b", c, addr_ok_l4, (c != 10)); end
            end
            next_cycle();
        end
        reset = 1'b0;
        set_idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_strobes();
        test_back_to_back();
        test_full();
        test_throttle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
